// File: rtl/vline_buffer.sv
// vline_buffer: two-line buffer emitting {bottom,center,top} pixel columns with edge-row replication
module vline_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int TAP_NUMS   = 3,
  parameter int MAX_WIDTH  = 1920,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          width_i,
  input  logic [ADDR_WIDTH-1:0]          height_i,
  input  logic                           valid_i,
  input  logic                           sof_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           ready_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [TAP_NUMS*DATA_WIDTH-1:0] data_o,
  output logic                           eol_o,
  output logic                           eof_o
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  state_t state;
  logic [DATA_WIDTH-1:0] l0 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] l1 [MAX_WIDTH];
  logic [ADDR_WIDTH-1:0] col, row, w_last, h_last;
  logic [DATA_WIDTH-1:0] p0, p1;
  logic adv, acc, we, last_col, last_row;
  assign p0       = l0[col];
  assign p1       = l1[col];
  assign adv      = !valid_o || ready_i;
  assign ready_o  = (state == IDLE || state == FILL) ? 1'b1 : (state == RUN) ? adv : 1'b0;
  assign acc      = valid_i && ready_o;
  assign we       = acc && (state == FILL || state == RUN || (state == IDLE && sof_i));
  assign last_col = col == w_last;
  assign last_row = row == h_last;
  always_ff @(posedge clk)
    if (we) begin
      l1[col] <= p0;
      l0[col] <= data_i;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      w_last  <= '0;
      h_last  <= '0;
      valid_o <= 1'b0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      if (adv) valid_o <= 1'b0;
      case (state)
        IDLE:
          if (acc && sof_i) begin
            w_last <= width_i - ONE;
            h_last <= height_i - ONE;
            // a one-pixel-wide line completes row 0 on the sof beat itself
            col    <= (width_i == ONE) ? '0 : ONE;
            row    <= (width_i == ONE && height_i != ONE) ? ONE : '0;
            state  <= (width_i != ONE) ? FILL : (height_i != ONE) ? RUN : FLUSH;
          end
        FILL:
          if (acc) begin
            col <= last_col ? '0 : col + ONE;
            if (last_col) begin
              row   <= (h_last == '0) ? '0 : ONE;
              state <= (h_last == '0) ? FLUSH : RUN;
            end
          end
        RUN:
          if (acc) begin
            valid_o <= 1'b1;
            data_o  <= {data_i, p0, (row == ONE) ? p0 : p1};
            eol_o   <= last_col;
            eof_o   <= 1'b0;
            col     <= last_col ? '0 : col + ONE;
            if (last_col) begin
              row <= last_row ? '0 : row + ONE;
              if (last_row) state <= FLUSH;
            end
          end
        FLUSH:
          if (adv) begin
            valid_o <= 1'b1;
            data_o  <= {p0, p0, (h_last == '0) ? p0 : p1};
            eol_o   <= last_col;
            eof_o   <= last_col;
            col     <= last_col ? '0 : col + ONE;
            if (last_col) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vline_buffer.sv
// tb_vline_buffer: scoreboard bench comparing vline_buffer against a frame-level column model
module tb_vline_buffer;
  localparam int DW = 8, AW = 11;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] width_i = '0, height_i = '0;
  logic valid_i = 1'b0, sof_i = 1'b0, ready_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic ready_o, valid_o, eol_o, eof_o;
  logic [3*DW-1:0] data_o;
  typedef struct {logic [23:0] d; logic eol; logic eof;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, rmode = 0;
  vline_buffer dut (
    .clk(clk), .rst(rst), .width_i(width_i), .height_i(height_i),
    .valid_i(valid_i), .sof_i(sof_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .eol_o(eol_o), .eof_o(eof_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~ready_i : (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end
  initial begin
    logic stall = 1'b0;
    logic [25:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (stall) begin
          chk("hold_valid", 64'(valid_o), 64'd1);
          chk("hold_beat", 64'({eol_o, eof_o, data_o}), 64'(held));
        end
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat got=%h t=%0t", data_o, $time);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("data", 64'(data_o), 64'(e.d));
            chk("eol", 64'(eol_o), 64'(e.eol));
            chk("eof", 64'(eof_o), 64'(e.eof));
          end
        end
        stall = valid_o && !ready_i;
        held = {eol_o, eof_o, data_o};
      end
    end
  end
  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0: return 8'(16 * r + c);
      2: return 8'(5 + c);
      3: return 8'(10 + r);
      default: return 8'($urandom);
    endcase
  endfunction
  task automatic send(input logic [7:0] d, input logic s);
    int t = 0;
    valid_i = 1'b1;
    data_i = d;
    sof_i = s;
    @(negedge clk);
    while (!ready_o && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) chk("send_timeout", 64'(ready_o), 64'd1);
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    sof_i = 1'b0;
  endtask
  task automatic run_frame(input int w, input int h, input int pat, input int maxgap, input int npix, input bit stray);
    logic [7:0] img[];
    int n;
    img = new[w * h];
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img[r * w + c] = pix(pat, r, c);
    width_i = AW'(w);
    height_i = AW'(h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        exp_t e;
        int rb, rt;
        rb = (r + 1 < h) ? r + 1 : h - 1;
        rt = (r > 0) ? r - 1 : 0;
        e.d = {img[rb * w + c], img[r * w + c], img[rt * w + c]};
        e.eol = (c == w - 1);
        e.eof = (c == w - 1) && (r == h - 1);
        q.push_back(e);
      end
    n = (npix < 0) ? w * h : npix;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk);
        #2;
      end
      send(img[i], (i == 0) || (stray && $urandom_range(0, 7) == 0));
    end
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #2;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_eol", 64'(eol_o), 64'd0);
    chk("rst_eof", 64'(eof_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_frame(4, 3, 0, 0, -1, 1'b0);
    drain();
    rmode = 1;
    run_frame(4, 3, 0, 2, -1, 1'b0);
    drain();
    rmode = 0;
    @(posedge clk);
    #2;
    run_frame(3, 1, 2, 0, -1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_ready", 64'(ready_o), 64'd0);
    end
    @(posedge clk);
    #2;
    drain();
    run_frame(1, 2, 3, 0, -1, 1'b0);
    drain();
    width_i = AW'(4);
    height_i = AW'(3);
    for (int i = 0; i < 3; i++) send(8'h77, 1'b0);
    run_frame(4, 3, 0, 0, -1, 1'b0);
    drain();
    rmode = 3;
    @(posedge clk);
    #2;
    run_frame(4, 3, 0, 0, 5, 1'b0);
    @(negedge clk);
    chk("pending_before_rst", 64'(valid_o), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_after_rst", 64'(valid_o), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    rmode = 0;
    run_frame(4, 3, 0, 0, -1, 1'b0);
    drain();
    rmode = 2;
    for (int f = 0; f < 12; f++) begin
      run_frame($urandom_range(1, 8), $urandom_range(1, 5), 1, 2, -1, 1'b1);
      drain();
    end
    run_frame(64, 3, 1, 1, -1, 1'b1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
